// File: rtl/cflog_pkg.sv
// Shared encodings for the CFLog writer: event entry layout, FSM states, words per entry.
package cflog_pkg;

    typedef enum logic {
        EVT_BR   = 1'b0,
        EVT_LOOP = 1'b1
    } evt_type_e;

    typedef struct packed {
        evt_type_e   typ;
        logic [31:0] payload;
    } evt_t;

    localparam int          EVT_W       = 33;
    localparam logic [15:0] LOOP_MARKER = 16'hFFFF;
    localparam int          WORDS_BR    = 2;
    localparam int          WORDS_LOOP  = 3;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_W0    = 3'd1;
    localparam logic [2:0] ST_W1    = 3'd2;
    localparam logic [2:0] ST_W2    = 3'd3;
    localparam logic [2:0] ST_FLUSH = 3'd4;

    function automatic evt_t mk_br(input logic [15:0] src, input logic [15:0] dest);
        evt_t e;
        e.typ     = EVT_BR;
        e.payload = {src, dest};
        return e;
    endfunction

    function automatic evt_t mk_loop(input logic [31:0] ctr);
        evt_t e;
        e.typ     = EVT_LOOP;
        e.payload = ctr;
        return e;
    endfunction

endpackage

// File: rtl/cflog_evt_fifo.sv
// Single-push / single-pop synchronous FIFO with show-ahead read data.
module cflog_evt_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wr;
    logic [AW:0]  r_rd;
    logic         w_wr;
    logic         w_rd;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign o_empty = (r_wr == r_rd);
    assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign w_wr    = i_push & ~o_full;
    assign w_rd    = i_pop & ~o_empty;
    assign o_data  = r_mem[r_rd[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr[AW-1:0]] <= i_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_wr) r_wr <= r_wr + 1'b1;
            if (w_rd) r_rd <= r_rd + 1'b1;
        end
    end

endmodule

// File: rtl/cflog_writer.sv
// Branch/loop events -> CFLog RAM words, with flush handshake when the log fills.
// CFLOG_LOOP_COMPRESS_EN enables loop suppression and LOOP records; otherwise every branch is a BR.
module cflog_writer
    import cflog_pkg::*;
#(
    parameter int LOG_SIZE  = 256,
    parameter int LOG_AW    = 8,
    parameter int CTR_SIZE  = 32,
    parameter int EVT_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                branch_detect,
    input  logic [15:0]         branch_src,
    input  logic [15:0]         branch_dest,
    input  logic                loop_detect,
    input  logic [CTR_SIZE-1:0] loop_ctr,
    input  logic                flush_ack,
    output logic                log_wr_en,
    output logic [LOG_AW-1:0]   log_wr_addr,
    output logic [15:0]         log_wr_data,
    output logic [LOG_AW:0]     log_ptr,
    output logic                flush_req,
    output logic                overflow
);
    localparam logic [LOG_AW+1:0] CAP       = (LOG_AW+2)'(LOG_SIZE);
    localparam logic [LOG_AW+1:0] NEED_BR   = (LOG_AW+2)'(WORDS_BR);
    localparam logic [LOG_AW+1:0] NEED_LOOP = (LOG_AW+2)'(WORDS_LOOP);

    evt_t              w_push_data;
    evt_t              w_head;
    evt_t              r_cur;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              w_lost;
    logic              w_fits;
    logic [LOG_AW+1:0] w_need;
    logic [LOG_AW+1:0] w_sum;
    logic [2:0]        r_state;
    logic [LOG_AW:0]   r_ptr;
    logic              r_ovf;

    cflog_evt_fifo #(
        .W     (EVT_W),
        .DEPTH (EVT_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

`ifdef CFLOG_LOOP_COMPRESS_EN
    logic                r_loop_active;
    logic                r_skid_vld;
    logic [31:0]         r_skid;
    logic [CTR_SIZE-1:0] r_last_ctr;
    logic                w_exit;
    logic                w_br_direct;
    logic                w_park;

    assign w_exit      = r_loop_active & ~loop_detect;
    assign w_br_direct = branch_detect & ~loop_detect & ~r_loop_active;
    assign w_park      = ~r_skid_vld & w_exit & branch_detect;
    assign w_need      = (w_head.typ == EVT_LOOP) ? NEED_LOOP : NEED_BR;

    // The skid owns the push port for its one cycle; anything new that cycle is lost.
    always_comb begin
        w_push      = 1'b0;
        w_push_data = '0;
        w_lost      = 1'b0;
        if (r_skid_vld) begin
            w_push      = 1'b1;
            w_push_data = mk_br(r_skid[31:16], r_skid[15:0]);
            w_lost      = w_exit | w_br_direct;
        end else if (w_exit) begin
            w_push      = 1'b1;
            w_push_data = mk_loop(r_last_ctr);
        end else if (w_br_direct) begin
            w_push      = 1'b1;
            w_push_data = mk_br(branch_src, branch_dest);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_loop_active <= 1'b0;
            r_skid_vld    <= 1'b0;
            r_skid        <= '0;
            r_last_ctr    <= '0;
        end else begin
            if (branch_detect & loop_detect) r_loop_active <= 1'b1;
            else if (w_exit)                 r_loop_active <= 1'b0;
            if (loop_detect) r_last_ctr <= loop_ctr;
            r_skid_vld <= w_park;
            if (w_park) r_skid <= {branch_src, branch_dest};
        end
    end
`else
    logic w_unused_cfg;

    assign w_push       = branch_detect;
    assign w_push_data  = mk_br(branch_src, branch_dest);
    assign w_lost       = 1'b0;
    assign w_need       = NEED_BR;
    assign w_unused_cfg = ^{loop_detect, loop_ctr, r_cur.typ};
`endif

    // An entry is only started when all of its words fit; otherwise the log is flushed first.
    assign w_sum  = {1'b0, r_ptr} + w_need;
    assign w_fits = (w_sum <= CAP);
    assign w_pop  = (r_state == ST_IDLE) & ~w_empty & w_fits;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_cur   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_lost | (w_push & w_full)) r_ovf <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        if (w_fits) begin
                            r_cur   <= w_head;
                            r_state <= ST_W0;
                        end else begin
                            r_state <= ST_FLUSH;
                        end
                    end
                end
                ST_W0: begin
                    r_ptr   <= r_ptr + 1'b1;
                    r_state <= ST_W1;
                end
                ST_W1: begin
                    r_ptr   <= r_ptr + 1'b1;
`ifdef CFLOG_LOOP_COMPRESS_EN
                    r_state <= (r_cur.typ == EVT_LOOP) ? ST_W2 : ST_IDLE;
`else
                    r_state <= ST_IDLE;
`endif
                end
`ifdef CFLOG_LOOP_COMPRESS_EN
                ST_W2: begin
                    r_ptr   <= r_ptr + 1'b1;
                    r_state <= ST_IDLE;
                end
`endif
                ST_FLUSH: begin
                    if (flush_ack) begin
                        r_ptr   <= '0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        log_wr_en   = 1'b0;
        log_wr_data = '0;
        case (r_state)
`ifdef CFLOG_LOOP_COMPRESS_EN
            ST_W0: begin
                log_wr_en   = 1'b1;
                log_wr_data = (r_cur.typ == EVT_LOOP) ? LOOP_MARKER : r_cur.payload[31:16];
            end
            ST_W1: begin
                log_wr_en   = 1'b1;
                log_wr_data = (r_cur.typ == EVT_LOOP) ? r_cur.payload[31:16] : r_cur.payload[15:0];
            end
            ST_W2: begin
                log_wr_en   = 1'b1;
                log_wr_data = r_cur.payload[15:0];
            end
`else
            ST_W0: begin
                log_wr_en   = 1'b1;
                log_wr_data = r_cur.payload[31:16];
            end
            ST_W1: begin
                log_wr_en   = 1'b1;
                log_wr_data = r_cur.payload[15:0];
            end
`endif
            default: ;
        endcase
    end

    assign log_wr_addr = r_ptr[LOG_AW-1:0];
    assign log_ptr     = r_ptr;
    assign flush_req   = (r_state == ST_FLUSH);
    assign overflow    = r_ovf;

endmodule

// File: tb/tb_cflog_writer.sv
// Directed bench for cflog_writer (LOG_SIZE=16); follows CFLOG_LOOP_COMPRESS_EN like the RTL.
module tb_cflog_writer;
    localparam int LOG_SIZE  = 16;
    localparam int LOG_AW    = 4;
    localparam int CTR_SIZE  = 32;
    localparam int EVT_DEPTH = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              branch_detect = 1'b0;
    logic [15:0]       branch_src = '0;
    logic [15:0]       branch_dest = '0;
    logic              loop_detect = 1'b0;
    logic [31:0]       loop_ctr = '0;
    logic              flush_ack = 1'b0;
    logic              log_wr_en;
    logic [LOG_AW-1:0] log_wr_addr;
    logic [15:0]       log_wr_data;
    logic [LOG_AW:0]   log_ptr;
    logic              flush_req;
    logic              overflow;

    int n_vec = 0;
    int n_err = 0;
    int exp_ptr = 0;
    logic [19:0] wq[$];

    cflog_writer #(
        .LOG_SIZE (LOG_SIZE), .LOG_AW (LOG_AW), .CTR_SIZE (CTR_SIZE), .EVT_DEPTH (EVT_DEPTH)
    ) dut (
        .clk (clk), .reset (reset), .branch_detect (branch_detect),
        .branch_src (branch_src), .branch_dest (branch_dest),
        .loop_detect (loop_detect), .loop_ctr (loop_ctr), .flush_ack (flush_ack),
        .log_wr_en (log_wr_en), .log_wr_addr (log_wr_addr), .log_wr_data (log_wr_data),
        .log_ptr (log_ptr), .flush_req (flush_req), .overflow (overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (log_wr_en) wq.push_back({log_wr_addr, log_wr_data});

    task automatic do_reset();
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        wq.delete();
        exp_ptr = 0;
    endtask

    task automatic send_br(input logic [15:0] s, input logic [15:0] d,
                           input logic ld, input logic [31:0] c);
        @(posedge clk); #1;
        branch_detect = 1'b1; branch_src = s; branch_dest = d;
        loop_detect = ld; loop_ctr = c;
        @(posedge clk); #1;
        branch_detect = 1'b0;
    endtask

    task automatic pulse_ack();
        @(posedge clk); #1 flush_ack = 1'b1;
        @(posedge clk); #1 flush_ack = 1'b0;
    endtask

    task automatic wait_words(input int n, input string tag);
        int t = 0;
        while (wq.size() < n && t < 200) begin
            @(negedge clk); #1;
            t++;
        end
        if (wq.size() < n) begin
            n_vec++; n_err++;
            $display("FAIL %s timeout: got %0d words, need %0d", tag, wq.size(), n);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_vec++;
        if ({log_wr_en, log_wr_addr, log_wr_data, log_ptr, flush_req, overflow} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: en=%b addr=%h data=%h ptr=%0d freq=%b ovf=%b, expected all 0",
                     log_wr_en, log_wr_addr, log_wr_data, log_ptr, flush_req, overflow);
        end
        do_reset();
    endtask

    task automatic test_branch();
        send_br(16'hE010, 16'hE100, 1'b0, 32'd0);
        @(negedge clk);
        n_vec++;
        if (log_wr_en !== 1'b0) begin
            n_err++; $display("FAIL br_lat_n1: en=%b, expected 0", log_wr_en);
        end
        @(negedge clk);
        n_vec++;
        if ({log_wr_en, log_wr_addr, log_wr_data} !== {1'b1, 4'd0, 16'hE010}) begin
            n_err++; $display("FAIL br_src: en=%b addr=%0d data=%h, expected 1/0/e010", log_wr_en, log_wr_addr, log_wr_data);
        end
        @(negedge clk);
        n_vec++;
        if ({log_wr_en, log_wr_addr, log_wr_data} !== {1'b1, 4'd1, 16'hE100}) begin
            n_err++; $display("FAIL br_dest: en=%b addr=%0d data=%h, expected 1/1/e100", log_wr_en, log_wr_addr, log_wr_data);
        end
        @(negedge clk);
        n_vec++;
        if (log_ptr !== 5'd2) begin
            n_err++; $display("FAIL br_ptr: got %0d, expected 2", log_ptr);
        end
        pulse_ack();
        @(negedge clk);
        n_vec++;
        if ({log_ptr, flush_req} !== {5'd2, 1'b0}) begin
            n_err++; $display("FAIL stray_ack: ptr=%0d freq=%b, expected 2/0", log_ptr, flush_req);
        end
        do_reset();
    endtask

    task automatic loop_stim();
        send_br(16'hE010, 16'hE000, 1'b0, 32'd0);
        for (int k = 2; k <= 5; k++) send_br(16'hE00E, 16'hE000, 1'b1, 32'(k));
        send_br(16'hE010, 16'hE012, 1'b0, 32'd5);
    endtask

`ifdef CFLOG_LOOP_COMPRESS_EN
    task automatic test_loop_compress();
        logic [15:0] ew [7];
        logic [19:0] got;
        ew = '{16'hE010, 16'hE000, 16'hFFFF, 16'h0000, 16'h0005, 16'hE010, 16'hE012};
        loop_stim();
        wait_words(7, "loop_words");
        for (int i = 0; i < 7; i++) begin
            got = (wq.size() > 0) ? wq.pop_front() : 20'hxxxxx;
            n_vec++;
            if (got !== {4'(i), ew[i]}) begin
                n_err++; $display("FAIL loop_word%0d: got %h, expected %h", i, got, {4'(i), ew[i]});
            end
        end
        repeat (4) @(negedge clk);
        n_vec++;
        if (log_ptr !== 5'd7 || wq.size() != 0) begin
            n_err++; $display("FAIL loop_ptr: ptr=%0d extra=%0d, expected 7/0", log_ptr, wq.size());
        end
        exp_ptr = 7;
    endtask
`else
    task automatic test_loop_ignored();
        logic [15:0] ew [12];
        logic [19:0] got;
        ew = '{16'hE010, 16'hE000, 16'hE00E, 16'hE000, 16'hE00E, 16'hE000,
               16'hE00E, 16'hE000, 16'hE00E, 16'hE000, 16'hE010, 16'hE012};
        loop_stim();
        wait_words(12, "noloop_words");
        for (int i = 0; i < 12; i++) begin
            got = (wq.size() > 0) ? wq.pop_front() : 20'hxxxxx;
            n_vec++;
            if (got !== {4'(i), ew[i]}) begin
                n_err++; $display("FAIL noloop_word%0d: got %h, expected %h", i, got, {4'(i), ew[i]});
            end
        end
        repeat (4) @(negedge clk);
        n_vec++;
        if (log_ptr !== 5'd12 || wq.size() != 0) begin
            n_err++; $display("FAIL noloop_ptr: ptr=%0d extra=%0d, expected 12/0", log_ptr, wq.size());
        end
        exp_ptr = 12;
    endtask
`endif

    task automatic fill_to_full();
        logic [19:0] got;
        while (exp_ptr + 2 <= LOG_SIZE) begin
            send_br(16'hC000 + 16'(exp_ptr), 16'hD000 + 16'(exp_ptr), 1'b0, 32'd0);
            wait_words(2, "fill");
            for (int j = 0; j < 2; j++) begin
                got = (wq.size() > 0) ? wq.pop_front() : 20'hxxxxx;
                n_vec++;
                if (got !== {4'(exp_ptr + j), (j == 0 ? 16'hC000 : 16'hD000) + 16'(exp_ptr)}) begin
                    n_err++; $display("FAIL fill_word@%0d: got %h", exp_ptr + j, got);
                end
            end
            exp_ptr += 2;
        end
        @(negedge clk);
    endtask

    task automatic test_flush();
        logic [19:0] got;
        fill_to_full();
        send_br(16'hE0F0, 16'hE0F1, 1'b0, 32'd0);
        repeat (6) @(negedge clk);
        n_vec++;
        if ({flush_req, log_wr_en, log_ptr} !== {1'b1, 1'b0, 5'(exp_ptr)} || wq.size() != 0) begin
            n_err++; $display("FAIL flush_hold: freq=%b en=%b ptr=%0d words=%0d, expected 1/0/%0d/0",
                              flush_req, log_wr_en, log_ptr, wq.size(), exp_ptr);
        end
        pulse_ack();
        @(negedge clk);
        n_vec++;
        if ({flush_req, log_ptr} !== {1'b0, 5'd0}) begin
            n_err++; $display("FAIL flush_release: freq=%b ptr=%0d, expected 0/0", flush_req, log_ptr);
        end
        wait_words(2, "flush_words");
        got = (wq.size() > 0) ? wq.pop_front() : 20'hxxxxx;
        n_vec++;
        if (got !== {4'd0, 16'hE0F0}) begin
            n_err++; $display("FAIL flush_src: got %h, expected 0e0f0", got);
        end
        got = (wq.size() > 0) ? wq.pop_front() : 20'hxxxxx;
        n_vec++;
        if (got !== {4'd1, 16'hE0F1}) begin
            n_err++; $display("FAIL flush_dest: got %h, expected 1e0f1", got);
        end
        @(negedge clk);
        n_vec++;
        if (log_ptr !== 5'd2) begin
            n_err++; $display("FAIL flush_ptr: got %0d, expected 2", log_ptr);
        end
        exp_ptr = 2;
    endtask

    task automatic test_overflow();
        logic [19:0] got;
        fill_to_full();
        for (int i = 0; i < 4; i++) send_br(16'hE300 + 16'(i), 16'hE400 + 16'(i), 1'b0, 32'd0);
        @(negedge clk);
        n_vec++;
        if ({flush_req, overflow} !== 2'b10) begin
            n_err++; $display("FAIL ovf_before: freq=%b ovf=%b, expected 1/0", flush_req, overflow);
        end
        send_br(16'hE304, 16'hE404, 1'b0, 32'd0);
        @(negedge clk);
        n_vec++;
        if ({flush_req, overflow} !== 2'b11 || wq.size() != 0) begin
            n_err++; $display("FAIL ovf_set: freq=%b ovf=%b words=%0d, expected 1/1/0", flush_req, overflow, wq.size());
        end
        pulse_ack();
        wait_words(8, "ovf_drain");
        for (int i = 0; i < 8; i++) begin
            got = (wq.size() > 0) ? wq.pop_front() : 20'hxxxxx;
            n_vec++;
            if (got !== {4'(i), ((i % 2) == 0 ? 16'hE300 : 16'hE400) + 16'(i / 2)}) begin
                n_err++; $display("FAIL ovf_word%0d: got %h", i, got);
            end
        end
        repeat (6) @(negedge clk);
        n_vec++;
        if ({log_ptr, overflow} !== {5'd8, 1'b1} || wq.size() != 0) begin
            n_err++; $display("FAIL ovf_sticky: ptr=%0d ovf=%b extra=%0d, expected 8/1/0", log_ptr, overflow, wq.size());
        end
        exp_ptr = 8;
    endtask

    task automatic test_reset_mid();
        logic [19:0] got;
        logic [15:0] w0;
        logic [15:0] w1;
`ifdef CFLOG_LOOP_COMPRESS_EN
        w0 = 16'hFFFF; w1 = 16'h1234;
`else
        w0 = 16'hE0AA; w1 = 16'hE0BB;
`endif
        send_br(16'hE0AA, 16'hE0BB, 1'b1, 32'h1234_5678);
        @(posedge clk); #1 loop_detect = 1'b0;
        wait_words(1, "mid_w0");
        got = (wq.size() > 0) ? wq.pop_front() : 20'hxxxxx;
        n_vec++;
        if (got !== {4'd8, w0}) begin
            n_err++; $display("FAIL mid_w0: got %h, expected %h", got, {4'd8, w0});
        end
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({log_wr_en, log_wr_addr, log_wr_data} !== {1'b1, 4'd9, w1}) begin
            n_err++; $display("FAIL mid_w1: en=%b addr=%0d data=%h, expected 1/9/%h", log_wr_en, log_wr_addr, log_wr_data, w1);
        end
        @(negedge clk);
        n_vec++;
        if ({log_wr_en, log_ptr, flush_req, overflow} !== '0) begin
            n_err++; $display("FAIL mid_reset: en=%b ptr=%0d freq=%b ovf=%b, expected all 0",
                              log_wr_en, log_ptr, flush_req, overflow);
        end
        @(posedge clk); #1 reset = 1'b0;
        wq.delete();
        repeat (10) @(negedge clk);
        n_vec++;
        if (wq.size() != 0 || log_ptr !== '0) begin
            n_err++; $display("FAIL mid_no_reissue: words=%0d ptr=%0d, expected 0/0", wq.size(), log_ptr);
        end
    endtask

    initial begin
        test_reset();
        test_branch();
`ifdef CFLOG_LOOP_COMPRESS_EN
        test_loop_compress();
`else
        test_loop_ignored();
`endif
        test_flush();
        test_overflow();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
